fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Instruction sequencer for the ARM7 core. It owns the PC, fetches one word per instruction over a simple req/ack memory port, and holds that word on the decoder's instr input. It pulses decode_en and waits out the decoder's fixed condition-check latency. It then consumes the decoder's branch result to compute the next PC and issue the link-register write.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
DECODE_CYCLES, 3, cycles after the decode_en sample edge during which branch_* is monitored; matches decoder latency.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = keep sequencing instructions
mem_req  output  1  fetch request, held until mem_ack
mem_addr  output  32  fetch address (= pc)
mem_ack  input  1  read data valid this cycle
mem_rdata  input  32  fetched word
instr  output  32  registered instruction to decoder, stable from DECODE through UPDATE
decode_en  output  1  one-cycle start pulse to decoder
branch_en  input  1  decoder branch result valid (one-cycle pulse)
branch_cond  input  1  condition passed
branch_link  input  1  BL (instr[24])
branch_offset  input  24  signed word offset
lr_we  output  1  one-cycle write strobe for r14
lr_wdata  output  32  link value
pc  output  32  address of instruction currently fetched/executing
busy  output  1  1 in any state other than IDLE
retired  output  32  count of completed instructions, wraps 2^32-1 -> 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC.
  - instr, lr_wdata, retired = 0.
  - mem_req, decode_en, lr_we, busy = 0.
- States: IDLE, FETCH, DECODE, WAIT, UPDATE.
- IDLE: if run=1 -> FETCH next cycle.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - On a cycle with mem_ack=1: instr<=mem_rdata, mem_req deasserts next cycle, -> DECODE.
  - No timeout; mem_ack on the first FETCH cycle is legal (1-cycle fetch).
- DECODE: decode_en=1 for exactly this cycle; -> WAIT, wait counter=0.
- WAIT:
  - Lasts exactly DECODE_CYCLES cycles.
  - Any cycle with branch_en=1: latch taken=branch_cond, link=branch_link, off=branch_offset. A later pulse overwrites the latch (last one wins).
  - Pulses outside WAIT are ignored.
  - Latches clear on entry to WAIT.
  - With the default decoder, branch_en arrives in WAIT cycle index 2.
- UPDATE (one cycle):
  - taken=1: pc <= pc + 8 + sign_extend(off,24->30) concatenated with 2'b00. 32-bit modulo arithmetic, wrap permitted.
  - Otherwise: pc <= pc + 4, modulo 2^32.
  - taken=1 and link=1: lr_we=1 this cycle, lr_wdata=pc+4, using the pre-update pc.
  - Branch with branch_cond=0 (not taken): no LR write, even if link=1.
  - retired <= retired+1.
  - Next state: FETCH if run=1, else IDLE.
- run deassertion mid-instruction does not abort; the instruction completes through UPDATE.
- instr changes only on mem_ack in FETCH; the decoder samples it combinationally in its last cycle.
- Total latency per instruction = fetch wait + 1 (DECODE) + DECODE_CYCLES + 1 (UPDATE); 6 cycles with 1-cycle memory.
- Reset mid-operation returns to IDLE immediately. Any in-flight branch latch and lr_we are discarded. The decoder may still emit a stale branch_en, which is ignored because the sequencer is not in WAIT.

Test Plan:
- Reset and run at RESET_PC=0; memory returns 32'hE1A00000 (non-branch); no branch_en -> pc goes 0,4,8; retired increments by 1 every 6 cycles; lr_we never asserts.
- Word 32'hEA000002 at 0x100: decoder pulses branch_en=1, branch_cond=1, link=0, offset=24'h000002 -> next mem_addr=0x110; lr_we=0.
- BL, offset=24'hFFFFFE at 0x200 with link=1, cond=1 -> pc=0x200; lr_we pulses one cycle with lr_wdata=0x204.
- Conditional branch failing at 0x40: branch_en=1, branch_cond=0, link=1 -> pc=0x44; no lr_we.
- Fetch stall: mem_ack delayed 4 cycles -> mem_req held 5 cycles with constant mem_addr; decode_en exactly one pulse after ack; instr equals mem_rdata captured on the ack cycle.
- Drop run during WAIT -> UPDATE completes, state returns to IDLE, busy=0. Assert rst_n=0 during a later WAIT -> pc=RESET_PC and all outputs zero asynchronously; a stale branch_en after reset is released does not change pc.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Purpose: ARM7 instruction sequencer: owns the PC, fetches, starts decode, and applies branch/link results.
// Latency: fetch wait + 1 decode + DECODE_CYCLES wait + 1 update (6 cycles with single-cycle memory).
// Backpressure: mem_req is held in FETCH until mem_ack; run=0 only takes effect after UPDATE.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          DECODE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        decode_en,
    input  logic        branch_en,
    input  logic        branch_cond,
    input  logic        branch_link,
    input  logic [23:0] branch_offset,
    output logic        lr_we,
    output logic [31:0] lr_wdata,
    output logic [31:0] pc,
    output logic        busy,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WAIT,
        S_UPDATE
    } state_t;

    localparam int          CW        = (DECODE_CYCLES > 1) ? $clog2(DECODE_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(DECODE_CYCLES - 1);

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   retired_q, retired_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          taken_q, taken_d;
    logic          link_q, link_d;
    logic [23:0]   off_q, off_d;

    logic [31:0]   seq_pc;
    logic [31:0]   br_target;

    // ARM branch target: PC reads as pc+8, offset is a signed word count.
    assign seq_pc    = pc_q + 32'd4;
    assign br_target = pc_q + 32'd8 + {{6{off_q[23]}}, off_q, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            wcnt_q    <= '0;
            taken_q   <= 1'b0;
            link_q    <= 1'b0;
            off_q     <= 24'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            wcnt_q    <= wcnt_d;
            taken_q   <= taken_d;
            link_q    <= link_d;
            off_q     <= off_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        wcnt_d      = wcnt_q;
        taken_d     = taken_q;
        link_d      = link_q;
        off_d       = off_q;
        mem_req     = 1'b0;
        decode_en   = 1'b0;
        lr_we       = 1'b0;
        lr_wdata    = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                decode_en = 1'b1;
                wcnt_d    = '0;
                taken_d   = 1'b0;
                link_d    = 1'b0;
                off_d     = 24'd0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // Last pulse inside the window wins.
                if (branch_en) begin
                    taken_d = branch_cond;
                    link_d  = branch_link;
                    off_d   = branch_offset;
                end
                if (wcnt_q == WAIT_LAST) begin
                    state_d = S_UPDATE;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            S_UPDATE: begin
                pc_d      = taken_q ? br_target : seq_pc;
                retired_d = retired_q + 32'd1;
                if (taken_q && link_q) begin
                    lr_we    = 1'b1;
                    lr_wdata = seq_pc;
                end
                state_d = run ? S_FETCH : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign instr    = instr_q;
    assign retired  = retired_q;
    assign busy     = (state_q != S_IDLE);

endmodule
